// File: rtl/skid_pipe.sv
// skid_pipe: chain of STAGES skid-buffer stages carrying WORD_WIDTH-bit words in strict FIFO order.
// Latency: a word accepted into an empty pipe is visible on out_data STAGES-1 cycles after the accepting edge.
// Backpressure: each stage absorbs one extra word in its skid register; in_ready is a pure register output.
// Ports:
//   clk, rstn (sync, active-low), flush (sync discard of all held words)
//   in_valid / in_ready / in_data    : upstream valid-ready handshake
//   out_valid / out_ready / out_data : downstream valid-ready handshake, driven straight from flops
//   count                            : words currently held, 0..2*STAGES
module skid_pipe #(
  parameter int                    WORD_WIDTH  = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    STAGES      = 1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WORD_WIDTH-1:0]              in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WORD_WIDTH-1:0]              out_data,
  output logic [$clog2(2*STAGES+1)-1:0]      count
);

  localparam int CW = $clog2(2*STAGES+1);

  // Per-stage state exported so neighbouring stages can see it.
  logic                  main_vld_a [STAGES];
  logic [WORD_WIDTH-1:0] main_dat_a [STAGES];
  logic                  skid_vld_a [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                  main_vld;
    logic [WORD_WIDTH-1:0] main_dat;
    logic                  skid_vld;
    logic [WORD_WIDTH-1:0] skid_dat;

    logic                  s_in_vld;
    logic [WORD_WIDTH-1:0] s_in_dat;
    logic                  s_out_rdy;
    logic                  accept;
    logic                  consume;
    logic                  main_load;

    if (k == 0) begin : g_first
      assign s_in_vld = in_valid;
      assign s_in_dat = in_data;
    end else begin : g_inner
      assign s_in_vld = main_vld_a[k-1];
      assign s_in_dat = main_dat_a[k-1];
    end

    // Downstream readiness is the next stage's registered "skid empty",
    // so out_ready never reaches in_ready combinationally.
    if (k == STAGES-1) begin : g_last
      assign s_out_rdy = out_ready;
    end else begin : g_mid
      assign s_out_rdy = ~skid_vld_a[k+1];
    end

    assign accept    = s_in_vld & ~skid_vld;
    assign consume   = main_vld & s_out_rdy;
    assign main_load = ~main_vld | consume;

    always_ff @(posedge clk) begin
      if (!rstn || flush) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
        main_dat <= RESET_VALUE;
        skid_dat <= RESET_VALUE;
      end else if (main_load) begin
        if (skid_vld) begin
          // Skid holds the older word; accept is impossible while skid is full.
          main_vld <= 1'b1;
          main_dat <= skid_dat;
          skid_vld <= 1'b0;
        end else begin
          main_vld <= accept;
          if (accept) begin
            main_dat <= s_in_dat;
          end
        end
      end else if (accept) begin
        // Main is stalled: park the incoming word.
        skid_vld <= 1'b1;
        skid_dat <= s_in_dat;
      end
    end

    assign main_vld_a[k] = main_vld;
    assign main_dat_a[k] = main_dat;
    assign skid_vld_a[k] = skid_vld;
  end

  assign in_ready  = ~skid_vld_a[0];
  assign out_valid = main_vld_a[STAGES-1];
  assign out_data  = main_dat_a[STAGES-1];

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_skid_pipe.sv
// tb_skid_pipe: three skid_pipe instances (STAGES 1, 2, 3; 8-bit words) driven by shared stimulus.
// Each instance has its own queue model updated from observed handshakes and checked every cycle.
// Directed phases pin latency, capacity, flush and reset with literal expectations.
module tb_skid_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       ir  [3];
  logic       ov  [3];
  logic [7:0] od  [3];
  logic [2:0] cnt [3];
  logic [1:0] c1;
  logic [2:0] c2;
  logic [2:0] c3;

  localparam int         SARR  [3] = '{1, 2, 3};
  localparam logic [7:0] RVARR [3] = '{8'h5A, 8'h5A, 8'hC3};

  skid_pipe #(.WORD_WIDTH(8), .RESET_VALUE(8'h5A), .STAGES(1)) d1 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .count(c1));

  skid_pipe #(.WORD_WIDTH(8), .RESET_VALUE(8'h5A), .STAGES(2)) d2 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .count(c2));

  skid_pipe #(.WORD_WIDTH(8), .RESET_VALUE(8'hC3), .STAGES(3)) d3 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .count(c3));

  assign cnt[0] = {1'b0, c1};
  assign cnt[1] = c2;
  assign cnt[2] = c3;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one FIFO queue per instance ----------------
  logic [7:0] mem   [3][64];
  int         hd    [3];
  int         tl    [3];
  int         run   [3];
  int         nout  [3];
  bit         armed [3];
  bit         fresh [3];
  bit         just  [3];
  bit         hold  [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      hd[i] = 0; tl[i] = 0; run[i] = 0; nout[i] = 0;
      armed[i] = 0; fresh[i] = 0; just[i] = 0; hold[i] = 0;
    end
  end

  // Compare on the falling edge, then record the handshakes that the next rising edge will take.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (armed[i]) begin
        int depth;
        depth = tl[i] - hd[i];
        chk($sformatf("count_d%0d", i), 32'(cnt[i]), 32'(depth));
        if (depth == 0) chk($sformatf("valid_when_empty_d%0d", i), 32'(ov[i]), 32'(0));
        if (ov[i]) chk($sformatf("head_data_d%0d", i), 32'(od[i]), 32'(mem[i][hd[i] % 64]));
        if (fresh[i] && !ov[i]) chk($sformatf("cleared_data_d%0d", i), 32'(od[i]), 32'(RVARR[i]));
        if (just[i]) chk($sformatf("ready_after_clear_d%0d", i), 32'(ir[i]), 32'(1));
        if (hold[i]) chk($sformatf("valid_held_d%0d", i), 32'(ov[i]), 32'(1));
        if (depth == 2*SARR[i]) chk($sformatf("ready_when_full_d%0d", i), 32'(ir[i]), 32'(0));
        if (SARR[i] == 1) chk("ready_vs_depth_d0", 32'(ir[i]), 32'(depth < 2));
        if (depth > 0 && !ov[i]) run[i]++;
        else                     run[i] = 0;
        chk($sformatf("stall_bound_d%0d", i), 32'(run[i] <= SARR[i]-1), 32'(1));
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (!rstn || flush) begin
        hd[i] = 0; tl[i] = 0; run[i] = 0;
        armed[i] = 1; fresh[i] = 1; just[i] = 1; hold[i] = 0;
      end else if (armed[i]) begin
        just[i] = 0;
        hold[i] = ov[i] && !out_ready;
        if (ov[i] && out_ready) begin
          hd[i]++;
          nout[i]++;
        end
        if (in_valid && ir[i]) begin
          mem[i][tl[i] % 64] = in_data;
          tl[i]++;
          fresh[i] = 0;
        end
      end
    end
  end

  // ---------------- stimulus and literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    int         j;
    int         n;
    int         cyc;
    int         base0;
    int         base2;
    bit         acc;
    logic [7:0] got [8];

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (2) tick();
    rstn = 1'b1;
    chk("reset_out_data_d0", 32'(od[0]), 32'h5A);
    chk("reset_count_d0",    32'(cnt[0]), 32'd0);
    chk("reset_in_ready_d0", 32'(ir[0]), 32'd1);
    chk("reset_out_data_d2", 32'(od[2]), 32'hC3);

    // Back-to-back 0x11,0x22,0x33 with out_ready=1.
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 8'h11; tick();
    chk("b2b_first_valid_d0", 32'(ov[0]), 32'd1);
    chk("b2b_first_data_d0",  32'(od[0]), 32'h11);
    chk("lat_not_yet_d1",     32'(ov[1]), 32'd0);
    chk("lat_not_yet_d2",     32'(ov[2]), 32'd0);
    in_data = 8'h22; tick();
    chk("b2b_second_data_d0", 32'(od[0]), 32'h22);
    chk("b2b_ready_d0",       32'(ir[0]), 32'd1);
    chk("b2b_count_d0",       32'(cnt[0]), 32'd1);
    chk("lat_arrive_d1",      32'(od[1]), 32'h11);
    chk("lat_still_empty_d2", 32'(ov[2]), 32'd0);
    in_data = 8'h33; tick();
    chk("b2b_third_data_d0",  32'(od[0]), 32'h33);
    chk("lat_arrive_d2",      32'(od[2]), 32'h11);
    in_valid = 1'b0; tick();
    chk("b2b_idle_valid_d0",  32'(ov[0]), 32'd0);
    chk("b2b_idle_count_d0",  32'(cnt[0]), 32'd0);
    drain();

    // Full throughput: in_ready never drops while out_ready is held high.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = 8'($urandom);
      tick();
      for (int i = 0; i < 3; i++) chk($sformatf("throughput_ready_d%0d", i), 32'(ir[i]), 32'd1);
    end
    drain();

    // Capacity of the two-stage instance: exactly four words, then drain in order.
    out_ready = 1'b0; j = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + j);
      acc = ir[1];
      tick();
      if (acc) j++;
    end
    chk("capacity_accepted_d1", 32'(j), 32'd4);
    chk("capacity_ready_d1",    32'(ir[1]), 32'd0);
    chk("capacity_count_d1",    32'(cnt[1]), 32'd4);
    out_ready = 1'b1; n = 0;
    for (int c = 0; c < 16; c++) begin
      in_valid = (j < 6);
      in_data  = 8'(8'hA0 + j);
      acc = ir[1] && in_valid;
      if (ov[1] && n < 8) begin
        got[n] = od[1];
        n++;
      end
      tick();
      if (acc) j++;
    end
    chk("capacity_emitted_d1", 32'(n), 32'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("capacity_order_%0d", k), 32'(got[k]), 32'(8'hA0 + k));
    drain();

    // Flush while the single-stage instance is full.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h77; tick();
    in_data = 8'h78; tick();
    in_valid = 1'b0;
    chk("flush_pre_count_d0", 32'(cnt[0]), 32'd2);
    chk("flush_pre_ready_d0", 32'(ir[0]), 32'd0);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count_d0", 32'(cnt[0]), 32'd0);
    chk("flush_valid_d0", 32'(ov[0]), 32'd0);
    chk("flush_data_d0",  32'(od[0]), 32'h5A);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("flush_no_emit_d0", 32'(ov[0]), 32'd0);
    end
    drain();

    // Reset mid-stream with three words held in the two-stage instance.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h31 + k);
      tick();
    end
    in_valid = 1'b0;
    chk("midreset_pre_count_d1", 32'(cnt[1]), 32'd3);
    rstn = 1'b0; in_valid = 1'b1; in_data = 8'h34;
    tick();
    rstn = 1'b1; in_valid = 1'b0;
    chk("midreset_count_d1", 32'(cnt[1]), 32'd0);
    chk("midreset_valid_d1", 32'(ov[1]), 32'd0);
    chk("midreset_data_d1",  32'(od[1]), 32'h5A);
    chk("midreset_ready_d1", 32'(ir[1]), 32'd1);
    in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; n = 0;
    for (int c = 0; c < 8; c++) begin
      if (ov[1] && n < 8) begin
        got[n] = od[1];
        n++;
      end
      tick();
    end
    chk("midreset_emitted_d1", 32'(n), 32'd1);
    chk("midreset_word_d1",    32'(got[0]), 32'h01);
    drain();

    // Random traffic until STAGES=1 and STAGES=3 have each delivered 10000 words.
    base0 = nout[0]; base2 = nout[2]; cyc = 0;
    while ((nout[0] - base0 < 10000 || nout[2] - base2 < 10000) && cyc < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 1999) == 0);
      tick();
      cyc++;
    end
    flush = 1'b0;
    chk("random_words_d0", 32'(nout[0] - base0 >= 10000), 32'd1);
    chk("random_words_d2", 32'(nout[2] - base2 >= 10000), 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/skid_pipe.md
SKID_PIPE -- requirements
Module: skid_pipe

Interface
REQ-001 Parameter WORD_WIDTH, default 32, payload width in bits; SHALL be >= 1.
REQ-002 Parameter RESET_VALUE, default 0, WORD_WIDTH-bit value held in every data register after reset or flush.
REQ-003 Parameter STAGES, default 1, number of chained skid stages; SHALL be >= 1.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous discard of all held words.
REQ-007 in_valid  input  1  upstream word valid.
REQ-008 in_ready  output  1  skid_pipe can accept a word this cycle.
REQ-009 in_data  input  WORD_WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream accepts a word this cycle.
REQ-012 out_data  output  WORD_WIDTH  downstream payload.
REQ-013 count  output  $clog2(2*STAGES+1)  number of words currently held, range 0..2*STAGES.

Function
REQ-014 A transfer occurs on an interface only in a cycle where valid and ready are both 1 at the rising edge.
REQ-015 Each stage SHALL contain one main register and one skid register, each with a valid bit; stage k output feeds stage k+1 input; stage 0 faces in_*, stage STAGES-1 faces out_*.
REQ-016 Stage in_ready SHALL be the registered negation of its skid valid bit; no combinational path from out_ready to in_ready.
REQ-017 Stage main register SHALL load when main is empty or its word is consumed this cycle; the source is the skid register if skid is valid, otherwise the stage input.
REQ-018 Stage skid register SHALL load the stage input when a word is accepted while main is valid and not consumed this cycle; skid SHALL clear when its word moves to main.
REQ-019 out_valid/out_data SHALL be driven directly from the last stage main register (registered outputs).
REQ-020 Latency: a word accepted at edge N into an empty pipe SHALL appear on out_data in the cycle after edge N+STAGES-1 (STAGES=1: visible immediately after edge N).
REQ-021 Throughput: with out_ready held 1, one word per cycle SHALL pass indefinitely with in_ready held 1.
REQ-022 Capacity: with out_ready held 0, exactly 2*STAGES words SHALL be accepted before in_ready falls to 0.
REQ-023 Order SHALL be strictly FIFO; no word duplicated or dropped except by flush or reset.
REQ-024 count SHALL be registered and change by +1 on an input-only transfer, -1 on an output-only transfer, 0 on simultaneous transfers.
REQ-025 Simultaneous in/out transfer when full: not possible since in_ready=0; when one word held, SHALL pass through with count unchanged.
REQ-026 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 flush=1 at an edge SHALL clear all valid bits, set count to 0, load RESET_VALUE into all data registers; any transfer on either side in that cycle SHALL be discarded and not counted.
REQ-028 flush has priority over all transfers; rstn has priority over flush.

Reset
REQ-029 While rstn=0 at an edge: all valid bits 0, data registers RESET_VALUE, count 0.
REQ-030 After reset: out_valid=0, out_data=RESET_VALUE, count=0, in_ready=1 from the first cycle after the reset edge.
REQ-031 Reset mid-stream SHALL discard all held words; no word from before reset appears at out_* afterward.

Verification
REQ-032 WORD_WIDTH=8, STAGES=1: send 0x11,0x22,0x33 back-to-back, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, in_ready stays 1, count stays <= 1.
REQ-033 STAGES=2, out_ready=0: offer 0xA0..0xA5 -> 0xA0..0xA3 accepted, in_ready=0 after 4th, count=4; raise out_ready -> 0xA0..0xA3 emitted in order, then 0xA4,0xA5.
REQ-034 STAGES=1 full (count=2), flush=1 with in_valid=1, out_ready=1 -> count=0, out_valid=0, out_data=RESET_VALUE next cycle, flushed input never emitted.
REQ-035 RESET_VALUE=0x5A: rstn=0 mid-stream with count=3 -> count=0, out_valid=0, out_data=0x5A; subsequent 0x01 emerges alone.
REQ-036 Random in_valid/out_ready (50%) over 10000 words, STAGES in {1,3} -> output sequence equals input sequence, count equals scoreboard depth every cycle, out_data stable under backpressure.
